ehl_ahb_arbiter: RTL

Per-slave master arbiter for the AHB matrix output stage: one instance sits in front of each slave port (including the default slave) and decides which master owns that slave's address phase. It uses round-robin across requesting masters, holds ownership for the whole of a defined-length burst or an undefined-length INCR burst, and tracks the data-phase owner for read-data and response steering. Outputs drive the output-stage address/control mux select and the per-master hready gating.

---
 rtl/ehl_ahb_arbiter_pkg.sv | 30 +++
 rtl/ehl_rr_pick.sv | 30 +++
 rtl/ehl_ahb_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ehl_ahb_arbiter_pkg.sv
// Shared AHB encodings for the matrix output stage, plus a helper that gives
// the number of SEQ beats a defined-length burst still has after its NONSEQ.
package ehl_ahb_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  // Zero means the burst does not take a fixed-length lock.
  function automatic logic [3:0] burst_remaining(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
      HBURST_WRAP16, HBURST_INCR16: return 4'd15;
      HBURST_SINGLE, HBURST_INCR:   return 4'd0;
      default:                      return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ehl_rr_pick.sv
// Combinational round-robin picker: first active request found scanning
// upward from start_i, wrapping at MNUM.
module ehl_rr_pick #(
  parameter int MNUM = 8
) (
  input  logic [MNUM-1:0] req_i,
  input  logic [3:0]      start_i,
  output logic [MNUM-1:0] pick_o,
  output logic [3:0]      idx_o,
  output logic            valid_o
);

  always_comb begin
    int pos;
    pos     = 0;
    pick_o  = '0;
    idx_o   = 4'd0;
    valid_o = 1'b0;
    for (int k = 0; k < MNUM; k++) begin
      pos = int'(start_i) + k;
      if (pos >= MNUM) pos = pos - MNUM;
      if (!valid_o && req_i[pos]) begin
        valid_o     = 1'b1;
        pick_o[pos] = 1'b1;
        idx_o       = 4'(pos);
      end
    end
  end

endmodule

// File: rtl/ehl_ahb_arbiter.sv
// Per-slave AHB master arbiter: round-robin address-phase grant with burst
// locking, plus data-phase owner tracking for response steering.
module ehl_ahb_arbiter
  import ehl_ahb_arbiter_pkg::*;
#(
  parameter int MNUM = 8
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic [MNUM*2-1:0] im_htrans,
  input  logic [MNUM*3-1:0] im_hburst,
  input  logic              is_hready,
  output logic [MNUM-1:0]   grant,
  output logic [3:0]        grant_idx,
  output logic              addr_valid,
  output logic [MNUM-1:0]   data_sel,
  output logic [3:0]        data_idx,
  output logic              data_valid,
  output logic              locked,
  output logic [MNUM-1:0]   wait_req
);

  typedef enum logic [1:0] {
    LK_UNLOCKED = 2'd0,
    LK_FIXED    = 2'd1,
    LK_INCR     = 2'd2
  } lock_e;

  localparam logic [3:0] LAST_IDX = 4'(MNUM - 1);

  lock_e           lock_q, lock_d;
  logic [3:0]      beat_q, beat_d;
  logic [MNUM-1:0] grant_q, grant_d;
  logic [3:0]      grant_idx_q, grant_idx_d;
  logic [MNUM-1:0] data_sel_q, data_sel_d;
  logic [3:0]      data_idx_q, data_idx_d;
  logic            data_valid_q, data_valid_d;

  logic [MNUM-1:0] req;
  logic [1:0]      own_trans;
  logic [2:0]      own_burst;
  logic [3:0]      rr_start;
  logic [MNUM-1:0] rr_pick;
  logic [3:0]      rr_idx;
  logic            rr_valid;

  always_comb begin
    req       = '0;
    own_trans = HTRANS_IDLE;
    own_burst = HBURST_SINGLE;
    for (int i = 0; i < MNUM; i++) begin
      req[i] = im_htrans[2*i+1];
      if (grant_q[i]) begin
        own_trans = im_htrans[2*i +: 2];
        own_burst = im_hburst[3*i +: 3];
      end
    end
  end

  // The current owner sits last in the scan order.
  assign rr_start = (grant_idx_q == LAST_IDX) ? 4'd0 : grant_idx_q + 4'd1;

  ehl_rr_pick #(.MNUM(MNUM)) u_rr_pick (
    .req_i   (req),
    .start_i (rr_start),
    .pick_o  (rr_pick),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  always_comb begin
    lock_d       = lock_q;
    beat_d       = beat_q;
    grant_d      = grant_q;
    grant_idx_d  = grant_idx_q;
    data_sel_d   = data_sel_q;
    data_idx_d   = data_idx_q;
    data_valid_d = data_valid_q;
    if (is_hready) begin
      // A NONSEQ from the owner always restarts lock evaluation, whatever the
      // current state, so an early-terminating burst re-locks in one edge.
      if (own_trans == HTRANS_NONSEQ) begin
        beat_d = burst_remaining(own_burst);
        if (own_burst == HBURST_INCR)
          lock_d = LK_INCR;
        else if (beat_d != 4'd0)
          lock_d = LK_FIXED;
        else
          lock_d = LK_UNLOCKED;
      end else begin
        case (lock_q)
          LK_FIXED: begin
            if (own_trans == HTRANS_SEQ) begin
              if (beat_q == 4'd1) begin
                lock_d = LK_UNLOCKED;
                beat_d = 4'd0;
              end else begin
                beat_d = beat_q - 4'd1;
              end
            end else if (own_trans == HTRANS_IDLE) begin
              lock_d = LK_UNLOCKED;
              beat_d = 4'd0;
            end
          end
          LK_INCR: begin
            if (own_trans == HTRANS_IDLE) lock_d = LK_UNLOCKED;
          end
          default: ;
        endcase
      end

      if (lock_d == LK_UNLOCKED && rr_valid) begin
        grant_d     = rr_pick;
        grant_idx_d = rr_idx;
      end

      data_valid_d = addr_valid;
      data_sel_d   = addr_valid ? grant_q : '0;
      data_idx_d   = addr_valid ? grant_idx_q : 4'd0;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      lock_q       <= LK_UNLOCKED;
      beat_q       <= 4'd0;
      grant_q      <= MNUM'(1);
      grant_idx_q  <= 4'd0;
      data_sel_q   <= '0;
      data_idx_q   <= 4'd0;
      data_valid_q <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      beat_q       <= beat_d;
      grant_q      <= grant_d;
      grant_idx_q  <= grant_idx_d;
      data_sel_q   <= data_sel_d;
      data_idx_q   <= data_idx_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign grant      = grant_q;
  assign grant_idx  = grant_idx_q;
  assign addr_valid = own_trans[1];
  assign data_sel   = data_sel_q;
  assign data_idx   = data_idx_q;
  assign data_valid = data_valid_q;
  assign locked     = (lock_q != LK_UNLOCKED);
  assign wait_req   = req & ~grant_q;

endmodule
